adc_scan_uart_tx: RTL
=====================

ADC_SCAN_UART_TX -- requirements
Module: adc_scan_uart_tx

Interface
REQ-001 SHALL have parameter NCH, default 8, number of multiplexed ADC channels (2..16).
REQ-002 SHALL have parameter DW, default 8, ADC sample width (4..16), with DW >= CW, where CW = clog2(NCH).
REQ-003 SHALL have parameter BAUD_DIV, default 105, clock cycles per serial bit (>= 4).
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-006 SHALL have port eoc, input, 1 bit: ADC end-of-conversion.
REQ-007 SHALL have port data_in, input, DW bits: ADC result.
REQ-008 SHALL have port dsr, input, 1 bit: receiver ready.
REQ-009 SHALL have port soc, output, 1 bit: start-of-conversion pulse.
REQ-010 SHALL have port mux_en, output, 1 bit: analog mux enable.
REQ-011 SHALL have port canale, output, CW bits: current mux channel.
REQ-012 SHALL have port load_dato, output, 1 bit: sample-capture strobe.
REQ-013 SHALL have port data_out, output, 1 bit: serial line, idle high.
REQ-014 SHALL have port busy, output, 1 bit: frame pair in progress.
REQ-015 SHALL have port error, output, 1 bit: sticky-until-success send error.

Function
REQ-016 The acquisition FSM SHALL have states A_MUX, A_SOC, A_WAIT, A_LOAD, A_TX, A_NEXT.
- A_MUX: mux_en=1, one cycle.
- A_SOC: soc=1 for exactly one cycle.
- A_WAIT: hold until eoc=1 is sampled; no timeout.
- A_LOAD: load_dato=1 one cycle; sample register <= data_in; mux_en=0.
- A_TX: wait for the transmitter to finish or reject.
- A_NEXT: canale increments, NCH-1 wraps to 0.
REQ-017 On entry to A_TX, the transmitter SHALL sample dsr.
- dsr=0: error=1; frames are skipped; go to A_NEXT the next cycle.
- dsr=1: error=0; busy=1; send frame H then frame D back-to-back.
REQ-018 Frame format SHALL be start bit 0, DW payload bits MSB first, then stop bit 1, each bit exactly BAUD_DIV cycles.
REQ-019 Frame H payload SHALL be canale zero-extended to DW; frame D payload SHALL be the captured sample.
REQ-020 The first start bit SHALL appear on data_out the cycle after the dsr sample.
- busy SHALL fall in the cycle after the last stop-bit cycle of frame D.
- A_NEXT SHALL follow in that same cycle.
REQ-021 dsr changes during a frame pair SHALL be ignored, as SHALL eoc outside A_WAIT.
REQ-022 The baud counter SHALL be CW-independent, clog2(BAUD_DIV) bits, and reset to 0 at each bit boundary; it SHALL never exceed BAUD_DIV-1.
REQ-023 data_out SHALL be 1 whenever busy=0.

Reset
REQ-024 While reset_n=0, the block SHALL be held in reset:
- state A_MUX; canale=0; sample register=0;
- soc, mux_en, load_dato, busy, error = 0; data_out=1;
- baud and bit counters = 0.
REQ-025 Reset asserted mid-frame SHALL force data_out=1 immediately (asynchronously); no partial frame SHALL resume after release.
REQ-026 The first cycle after reset release SHALL be A_MUX with canale=0.

Configuration
REQ-027 With macro ADC_SCAN_UART_TX_PARITY_EN defined, each frame SHALL insert an even-parity bit (XOR of the payload) between the payload LSB and the stop bit, giving a frame of DW+3 bits.
REQ-028 Without ADC_SCAN_UART_TX_PARITY_EN, frames SHALL be DW+2 bits with no parity logic present.

Verification
REQ-029 Reset, dsr=1, eoc pulsed 3 cycles after soc, data_in=8'hA5 -> frame H payload 8'h00, frame D 0,1,0,1,0,0,1,0,1,1; each bit 105 cycles; canale=1 afterwards.
REQ-030 dsr=0 at A_TX entry -> error=1, data_out stays 1, canale advances; next cycle with dsr=1 -> error=0.
REQ-031 Run NCH=8 for 9 samples -> canale sequence 0..7,0; frame H payloads match.
REQ-032 reset_n low mid-frame D -> data_out=1 in the same cycle; after release, soc pulses again with canale=0.
REQ-033 Parity build, data_in=8'h07 -> parity bit 1 before stop; frame length 11x105 cycles.
REQ-034 eoc held low for 1000 cycles -> FSM stays in A_WAIT, soc stays 0, data_out stays 1.

Source files
------------

// File: rtl/adc_scan_uart_tx_if.sv
// ADC / serial-line signal bundle for adc_scan_uart_tx.
// master = the scanner block, slave = the ADC + receiver side.
interface adc_scan_uart_tx_if #(
    parameter int unsigned NCH = 8,
    parameter int unsigned DW  = 8
);
    localparam int unsigned CW = $clog2(NCH);

    logic          eoc;
    logic [DW-1:0] data_in;
    logic          dsr;
    logic          soc;
    logic          mux_en;
    logic [CW-1:0] canale;
    logic          load_dato;
    logic          data_out;
    logic          busy;
    logic          error;

    modport master (
        input  eoc, data_in, dsr,
        output soc, mux_en, canale, load_dato, data_out, busy, error
    );

    modport slave (
        output eoc, data_in, dsr,
        input  soc, mux_en, canale, load_dato, data_out, busy, error
    );
endinterface

// File: rtl/adc_scan_uart_tx.sv
// Round-robin ADC scanner that ships each sample as a header frame (channel) plus a data frame.
// Define ADC_SCAN_UART_TX_PARITY_EN to append an even-parity bit to every frame.
module adc_scan_uart_tx #(
    parameter int unsigned NCH      = 8,
    parameter int unsigned DW       = 8,
    parameter int unsigned BAUD_DIV = 105
) (
    input  logic               clock,
    input  logic               reset_n,
    adc_scan_uart_tx_if.master bus
);
    localparam int unsigned CW = $clog2(NCH);
    localparam int unsigned BW = $clog2(BAUD_DIV);
`ifdef ADC_SCAN_UART_TX_PARITY_EN
    localparam int unsigned NBITS = DW + 3;
`else
    localparam int unsigned NBITS = DW + 2;
`endif
    localparam int unsigned NW = $clog2(NBITS);

    typedef enum logic [2:0] {StMux, StSoc, StWait, StLoad, StTx, StNext} state_e;

    state_e        r_state, w_state_next;
    logic [CW-1:0] r_canale;
    logic [DW-1:0] r_sample;
    logic [BW-1:0] r_baud;
    logic [NW-1:0] r_bit;
    logic          r_frame;
    logic          r_busy;
    logic          r_error;

    logic          w_bit_end;
    logic          w_pair_end;
    logic          w_start;
    logic          w_reject;
    logic [DW-1:0] w_payload;
    logic [DW-1:0] w_shift;
    logic          w_txd;

    assign w_bit_end  = (r_baud == BW'(BAUD_DIV - 1));
    assign w_pair_end = r_busy && r_frame && w_bit_end && (r_bit == NW'(NBITS - 1));
    // dsr is only looked at in the first A_TX cycle, before busy rises
    assign w_start    = (r_state == StTx) && !r_busy && bus.dsr;
    assign w_reject   = (r_state == StTx) && !r_busy && !bus.dsr;
    assign w_payload  = r_frame ? r_sample : DW'(r_canale);
    assign w_shift    = w_payload << (r_bit - 1'b1);

    always_comb begin
        w_txd = 1'b1;
        if (r_bit == '0) begin
            w_txd = 1'b0;
        end else if (r_bit <= NW'(DW)) begin
            w_txd = w_shift[DW-1];
`ifdef ADC_SCAN_UART_TX_PARITY_EN
        end else if (r_bit == NW'(DW + 1)) begin
            w_txd = ^w_payload;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StMux;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StMux:   w_state_next = StSoc;
            StSoc:   w_state_next = StWait;
            StWait:  if (bus.eoc) w_state_next = StLoad;
            StLoad:  w_state_next = StTx;
            StTx:    if (w_reject || w_pair_end) w_state_next = StNext;
            StNext:  w_state_next = StMux;
            default: w_state_next = StMux;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_canale <= '0;
            r_sample <= '0;
            r_baud   <= '0;
            r_bit    <= '0;
            r_frame  <= 1'b0;
            r_busy   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            if (r_state == StLoad) r_sample <= bus.data_in;
            if (r_state == StNext) begin
                r_canale <= (r_canale == CW'(NCH - 1)) ? '0 : r_canale + 1'b1;
            end
            if (w_reject) r_error <= 1'b1;
            if (w_start) begin
                r_error <= 1'b0;
                r_busy  <= 1'b1;
                r_baud  <= '0;
                r_bit   <= '0;
                r_frame <= 1'b0;
            end else if (r_busy) begin
                if (w_bit_end) begin
                    r_baud <= '0;
                    if (r_bit == NW'(NBITS - 1)) begin
                        r_bit   <= '0;
                        r_frame <= 1'b0;
                        if (!r_frame) r_frame <= 1'b1;
                        else          r_busy  <= 1'b0;
                    end else begin
                        r_bit <= r_bit + 1'b1;
                    end
                end else begin
                    r_baud <= r_baud + 1'b1;
                end
            end
        end
    end

    // Gated by reset_n so the mux is off while held in reset even though the state is A_MUX
    assign bus.mux_en    = reset_n && (r_state inside {StMux, StSoc, StWait});
    assign bus.soc       = (r_state == StSoc);
    assign bus.load_dato = (r_state == StLoad);
    assign bus.canale    = r_canale;
    assign bus.busy      = r_busy;
    assign bus.error     = r_error;
    assign bus.data_out  = r_busy ? w_txd : 1'b1;
endmodule
